// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operand-signedness decode for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ITER     = 32;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned REG_W    = 5;

    localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
    localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
    localparam logic [OP_W-1:0] OP_DIV    = 3'd4;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'd5;
    localparam logic [OP_W-1:0] OP_REM    = 3'd6;
    localparam logic [OP_W-1:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic is_signed_a(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 step: shift-add multiply (div_mode=0) or restoring divide (div_mode=1).
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              div_mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_nxt_c
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] rem_sub;

    // mul: acc = {partial product, multiplier}; div: acc = {partial remainder, dividend/quotient}
    always_comb begin
        sum       = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        shifted   = acc[2*XLEN-1:XLEN-1];
        fits      = (shifted >= {1'b0, opnd});
        // when the divisor fits, the true difference is below the divisor, so 32 bits are exact
        rem_sub   = shifted[XLEN-1:0] - opnd;
        acc_nxt_c = {sum, acc[XLEN-1:1]};
        if (div_mode) begin
            acc_nxt_c = fits ? {rem_sub, acc[XLEN-2:0], 1'b1}
                             : {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit between register-file read and write ports.
// Define MULDIV_FAST_MUL_EN to route MUL* ops through a single-cycle combinational multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              kill,
    input  logic [OP_W-1:0]   op,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [REG_W-1:0]  rd_in,
    output logic              busy,
    output logic              done,
    output logic              we,
    output logic [REG_W-1:0]  rd_out,
    output logic [XLEN-1:0]   result
);

    localparam int unsigned AW = 2 * XLEN;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [AW-1:0]     acc_q;
    logic [AW-1:0]     step_acc;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   rs1_q;
    logic [OP_W-1:0]   op_q;
    logic              sa_q, sb_q, dz_q;

    logic              launch, step_en, fix_en, fast_path;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [AW-1:0]     prod;
    logic [XLEN-1:0]   quot, remd, fix_res;

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN-1:0]   rs2_q;
    assign fast_path = ~op[2];
`else
    assign fast_path = 1'b0;
`endif

    // operand magnitudes and effective signs at launch
    always_comb begin
        sign_a = is_signed_a(op) & rs1_val[XLEN-1];
        sign_b = is_signed_b(op) & rs2_val[XLEN-1];
        mag_a  = sign_a ? -rs1_val : rs1_val;
        mag_b  = sign_b ? -rs2_val : rs2_val;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode  (op_q[2]),
        .acc       (acc_q),
        .opnd      (opnd_q),
        .acc_nxt_c (step_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start && !kill) begin
                    launch  = 1'b1;
                    state_d = fast_path ? ST_FIX : ST_CALC;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt_q == '0) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    fix_en  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // sign correction and result selection; divide-by-zero overrides the iterated values
    always_comb begin
        prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
`ifdef MULDIV_FAST_MUL_EN
        prod = {{XLEN{sa_q}}, rs1_q} * {{XLEN{sb_q}}, rs2_q};
`endif
        quot = dz_q ? {XLEN{1'b1}}
                    : ((sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
        remd = dz_q ? rs1_q
                    : (sa_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN]);
        fix_res = prod[XLEN-1:0];
        case (op_q)
            OP_MUL:                       fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[AW-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quot;
            default:                      fix_res = remd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            we     <= 1'b0;
            rd_out <= '0;
            result <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            rs1_q  <= '0;
            op_q   <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            dz_q   <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            rs2_q  <= '0;
`endif
        end else begin
            busy <= (state_d == ST_CALC) || (state_d == ST_FIX);
            done <= (state_d == ST_DONE);
            we   <= (state_d == ST_DONE) && (rd_out != '0);
            if (launch) begin
                op_q   <= op;
                rd_out <= rd_in;
                sa_q   <= sign_a;
                sb_q   <= sign_b;
                dz_q   <= (rs2_val == '0);
                rs1_q  <= rs1_val;
                cnt_q  <= CNT_W'(ITER - 1);
                acc_q  <= op[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                opnd_q <= op[2] ? mag_b : mag_a;
`ifdef MULDIV_FAST_MUL_EN
                rs2_q  <= rs2_val;
`endif
            end else if (step_en) begin
                acc_q <= step_acc;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (fix_en) result <= fix_res;
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register file read ports (rs1/rs2 operands) and upstream of its write port (result, destination index, write enable). Accepts one operation per start pulse, computes over a fixed number of cycles with a shift-add / restoring-divide datapath, then issues a one-cycle register-file write. The core stalls on `busy`.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: launch operation; sampled only when `busy`=0.
- `kill` input 1: abort in-flight operation (pipeline flush).
- `op` input 3: funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_val` input 32: operand A (register file RD1).
- `rs2_val` input 32: operand B (register file RD2).
- `rd_in` input 5: destination register index.
- `busy` output 1: operation in flight; new `start` ignored.
- `done` output 1: one-cycle completion pulse.
- `we` output 1: register-file write enable (drives WE3); equals `done` && `rd_out`≠0.
- `rd_out` output 5: destination index (drives A3), held from launch.
- `result` output 32: final value (drives WD3), held until next completion.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + `start`: latch `op`, `rd_in`; convert signed operands to magnitude and record result sign; load 6-bit counter = 31; go CALC.
- CALC: one radix-2 step per cycle (multiply: conditional add + shift of 64-bit accumulator; divide: restoring subtract + shift of 33-bit partial remainder). Counter 0 → FIX.
- FIX: apply sign correction; select low/high product or quotient/remainder; register `result`; go DONE.
- DONE: `done`=1 and `we` as defined for exactly one cycle; next state IDLE unless `start`=1 (back-to-back launch).
- Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; MUL low 32 bits regardless.
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU), remainder = rs1_val. Latency unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0. Latency unchanged.
- Remainder sign follows dividend; quotient truncates toward zero.
- `kill` in CALC/FIX: go IDLE next cycle, no `done`, no `we`, `result` keeps prior value. `kill` with `start` in same IDLE cycle: start ignored.
- `start` while `busy`=1: ignored, no effect on in-flight operation.

## Timing
- Reset values: `busy`=0, `done`=0, `we`=0, `rd_out`=0, `result`=0, state IDLE, counter 0.
- `reset` mid-operation: all of the above on the next edge; in-flight result discarded.
- `start` high in cycle 0 → `busy`=1 cycles 1–33 (CALC 1–32, FIX 33) → `done`=1 cycle 34, `busy`=0 in cycle 34.
- Back-to-back: `start` in cycle 34 (DONE) → next `done` in cycle 68.
- `result`/`rd_out` valid from cycle 34 and stable until the next `done`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: ops 0–3 skip CALC; IDLE → FIX uses a combinational 33×33 signed multiplier; `start` cycle 0 → `done` cycle 2. Divides unchanged (34).
- Not defined: all ops use the iterative path, fixed 34-cycle latency; no hardware multiplier inferred.

## Structure
- Shared package `muldiv_pkg`: `op` funct3 localparams, state encoding (IDLE=0, CALC=1, FIX=2, DONE=3), iteration count constant 32.
- One sub-module `muldiv_step`: purely combinational single radix-2 step (mul add-shift / div subtract-shift selected by a mode bit); FSM, counter, sign handling and output registers stay in `muldiv_unit`.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), rd=5 → `done` cycle 34, `result`=0xFFFFFFEB, `we`=1, `rd_out`=5 (cycle 2 with `MULDIV_FAST_MUL_EN`).
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF, REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0; all at cycle 34.
- `kill` at cycle 10 of a DIV → IDLE at cycle 11, no `done`/`we`, `result` unchanged; `start` at cycle 20 while busy from a prior start → ignored.
- `reset` at cycle 15 mid-op → all outputs 0 next cycle; rd=0 op → `done`=1, `we`=0; back-to-back start in DONE → second `done` 34 cycles later.
